// File: rtl/bpu_pkg.sv
// Shared definitions for the bimodal branch predictor: widths, branch opcode
// range, 2-bit counter encodings and small decode/update helpers.
package bpu_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic [5:0] BR_OP_MIN = 6'h12;
    localparam logic [5:0] BR_OP_MAX = 6'h1B;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_STRONG_NT = 2'b00;
    localparam cnt_t CNT_WNT       = 2'b01;
    localparam cnt_t CNT_STRONG_T  = 2'b11;

    function automatic logic is_branch_op(input logic [INST_W-1:0] inst);
        return (inst[31:26] >= BR_OP_MIN) && (inst[31:26] <= BR_OP_MAX);
    endfunction

    // Saturating 2-bit counter step towards the resolved direction.
    function automatic cnt_t cnt_next(input cnt_t cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_STRONG_T) ? cnt : cnt + 2'd1;
        end
        return (cnt == CNT_STRONG_NT) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/bpu_bimodal_predictor_if.sv
// Fetch-side, predict-side and update-side signals of the branch predictor.
// Signal suffixes are from the predictor's point of view.
interface bpu_bimodal_predictor_if #(
    parameter int unsigned FETCH_WIDTH = 2
);
    localparam int unsigned SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int unsigned GRP_W  = bpu_pkg::INST_W * FETCH_WIDTH;

    logic                   fetch_valid_i;
    logic                   fetch_ready_o;
    logic [31:0]            pc_i;
    logic [GRP_W-1:0]       inst_i;

    logic                   pred_valid_o;
    logic                   pred_ready_i;
    logic [31:0]            pc_o;
    logic [GRP_W-1:0]       inst_o;
    logic [FETCH_WIDTH-1:0] inst_en_o;
    logic [FETCH_WIDTH-1:0] is_branch_o;
    logic                   taken_o;
    logic [SLOT_W-1:0]      taken_slot_o;
    logic [31:0]            branch_target_o;

    logic                   upd_valid_i;
    logic [31:0]            upd_pc_i;
    logic                   upd_taken_i;
    logic [31:0]            upd_target_i;

    modport slave (
        input  fetch_valid_i, pc_i, inst_i, pred_ready_i,
        input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        output fetch_ready_o, pred_valid_o, pc_o, inst_o, inst_en_o, is_branch_o,
        output taken_o, taken_slot_o, branch_target_o
    );

    modport master (
        output fetch_valid_i, pc_i, inst_i, pred_ready_i,
        output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  fetch_ready_o, pred_valid_o, pc_o, inst_o, inst_en_o, is_branch_o,
        input  taken_o, taken_slot_o, branch_target_o
    );

endinterface

// File: rtl/bpu_pred_table.sv
// BHT (2-bit counters) and tagged BTB storage with NUM_RD asynchronous read
// ports and one synchronous write port. Addresses are word PCs (pc[31:2]).
module bpu_pred_table
    import bpu_pkg::*;
#(
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned DEPTH  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_RD-1:0][29:0] rd_wpc_i,
    output logic [NUM_RD-1:0]       rd_cnt_taken_o,
    output logic [NUM_RD-1:0]       rd_btb_hit_o,
    output logic [NUM_RD-1:0][31:0] rd_btb_target_o,
    input  logic                    wr_valid_i,
    input  logic [29:0]             wr_wpc_i,
    input  logic                    wr_taken_i,
    input  logic [31:0]             wr_target_i
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned TAG_W = 30 - IDX_W;

    cnt_t [DEPTH-1:0]             cnt_q, cnt_d;
    logic [DEPTH-1:0]             btb_valid_q, btb_valid_d;
    logic [DEPTH-1:0][TAG_W-1:0]  btb_tag_q, btb_tag_d;
    logic [DEPTH-1:0][31:0]       btb_target_q, btb_target_d;

    logic [NUM_RD-1:0][IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0]             wr_idx;

    assign wr_idx = wr_wpc_i[IDX_W-1:0];

    // Reads come straight from the _q state, so a same-cycle write is not visible.
    always_comb begin
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_idx[k]          = rd_wpc_i[k][IDX_W-1:0];
            rd_cnt_taken_o[k]  = cnt_q[rd_idx[k]][1];
            rd_btb_hit_o[k]    = btb_valid_q[rd_idx[k]] &&
                                 (btb_tag_q[rd_idx[k]] == rd_wpc_i[k][IDX_W +: TAG_W]);
            rd_btb_target_o[k] = btb_target_q[rd_idx[k]];
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        if (wr_valid_i) begin
            cnt_d[wr_idx] = cnt_next(cnt_q[wr_idx], wr_taken_i);
            if (wr_taken_i) begin
                btb_valid_d[wr_idx]  = 1'b1;
                btb_tag_d[wr_idx]    = wr_wpc_i[IDX_W +: TAG_W];
                btb_target_d[wr_idx] = wr_target_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= {DEPTH{CNT_WNT}};
            btb_valid_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            btb_valid_q <= btb_valid_d;
        end
    end

    // Tag/target payload is qualified by the valid bit and needs no reset.
    always_ff @(posedge clk) begin
        btb_tag_q    <= btb_tag_d;
        btb_target_q <= btb_target_d;
    end

endmodule

// File: rtl/bpu_bimodal_predictor.sv
// Bimodal front-end predictor: decodes branch slots, looks up BHT/BTB, keeps
// slots up to the first predicted-taken one and registers the result.
module bpu_bimodal_predictor
    import bpu_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned BHT_DEPTH   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    bpu_bimodal_predictor_if.slave bus
);
    localparam int unsigned SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int unsigned GRP_W  = INST_W * FETCH_WIDTH;

    logic [FETCH_WIDTH-1:0][29:0] slot_wpc;
    logic [FETCH_WIDTH-1:0]       slot_is_br;
    logic [FETCH_WIDTH-1:0]       slot_cnt_taken;
    logic [FETCH_WIDTH-1:0]       slot_btb_hit;
    logic [FETCH_WIDTH-1:0][31:0] slot_btb_target;

    logic                   grp_taken;
    logic [SLOT_W-1:0]      grp_slot;
    logic [31:0]            grp_target;
    logic [FETCH_WIDTH-1:0] grp_en;

    logic                   valid_q, valid_d;
    logic [31:0]            pc_q, pc_d;
    logic [GRP_W-1:0]       inst_q, inst_d;
    logic [FETCH_WIDTH-1:0] en_q, en_d;
    logic [FETCH_WIDTH-1:0] br_q, br_d;
    logic                   taken_q, taken_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [31:0]            target_q, target_d;

    logic fetch_ready;
    logic unused_upd_pc;

    assign unused_upd_pc = ^bus.upd_pc_i[1:0];

    // Word-PC increment wraps mod 2^30, matching pc_i + 4*k mod 2^32.
    always_comb begin
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            slot_wpc[k]   = bus.pc_i[31:2] + 30'(k);
            slot_is_br[k] = is_branch_op(bus.inst_i[INST_W*k +: INST_W]);
        end
    end

    bpu_pred_table #(
        .NUM_RD (FETCH_WIDTH),
        .DEPTH  (BHT_DEPTH)
    ) u_table (
        .clk             (clk),
        .rst             (rst),
        .rd_wpc_i        (slot_wpc),
        .rd_cnt_taken_o  (slot_cnt_taken),
        .rd_btb_hit_o    (slot_btb_hit),
        .rd_btb_target_o (slot_btb_target),
        .wr_valid_i      (bus.upd_valid_i),
        .wr_wpc_i        (bus.upd_pc_i[31:2]),
        .wr_taken_i      (bus.upd_taken_i),
        .wr_target_i     (bus.upd_target_i)
    );

    // Lowest predicted-taken slot wins; later slots are dropped.
    always_comb begin
        grp_taken  = 1'b0;
        grp_slot   = '0;
        grp_target = '0;
        grp_en     = '1;
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            if (grp_taken) begin
                grp_en[k] = 1'b0;
            end else if (slot_is_br[k] && slot_cnt_taken[k] && slot_btb_hit[k]) begin
                grp_taken  = 1'b1;
                grp_slot   = SLOT_W'(k);
                grp_target = slot_btb_target[k];
            end
        end
    end

    assign fetch_ready = ~valid_q | bus.pred_ready_i;

    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        en_d     = en_q;
        br_d     = br_q;
        taken_d  = taken_q;
        slot_d   = slot_q;
        target_d = target_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (fetch_ready) begin
            valid_d = bus.fetch_valid_i;
            if (bus.fetch_valid_i) begin
                pc_d     = bus.pc_i;
                inst_d   = bus.inst_i;
                en_d     = grp_en;
                br_d     = slot_is_br;
                taken_d  = grp_taken;
                slot_d   = grp_slot;
                target_d = grp_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            inst_q   <= '0;
            en_q     <= '0;
            br_q     <= '0;
            taken_q  <= 1'b0;
            slot_q   <= '0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            en_q     <= en_d;
            br_q     <= br_d;
            taken_q  <= taken_d;
            slot_q   <= slot_d;
            target_q <= target_d;
        end
    end

    assign bus.fetch_ready_o   = fetch_ready;
    assign bus.pred_valid_o    = valid_q;
    assign bus.pc_o            = pc_q;
    assign bus.inst_o          = inst_q;
    assign bus.inst_en_o       = en_q;
    assign bus.is_branch_o     = br_q;
    assign bus.taken_o         = taken_q;
    assign bus.taken_slot_o    = slot_q;
    assign bus.branch_target_o = target_q;

endmodule

// File: tb/tb_bpu_bimodal_predictor.sv
// Scoreboard bench: a FW=2/64-entry and a FW=4/16-entry predictor checked
// against a behavioural BHT/BTB model.
module tb_bpu_bimodal_predictor;
    import bpu_pkg::*;

    localparam logic [31:0] ADD  = 32'h0043_1020;
    localparam logic [31:0] BR   = 32'h5800_0010;
    localparam logic [31:0] BRLO = 32'h4800_0000;
    localparam logic [31:0] BRHI = 32'h6C00_0000;
    localparam logic [31:0] NBLO = 32'h4400_0000;
    localparam logic [31:0] NBHI = 32'h7000_0000;

    typedef struct {
        logic [31:0]  pc;
        logic [127:0] inst;
        logic [3:0]   en;
        logic [3:0]   br;
        logic         taken;
        logic [1:0]   slot;
        logic [31:0]  tgt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b, flush_a, flush_b;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    logic [1:0]  m_cnt [2][64];
    logic        m_val [2][64];
    logic [31:0] m_tag [2][64];
    logic [31:0] m_tgt [2][64];

    always #5 clk = ~clk;

    bpu_bimodal_predictor_if #(.FETCH_WIDTH(2)) if_a ();
    bpu_bimodal_predictor_if #(.FETCH_WIDTH(4)) if_b ();

    bpu_bimodal_predictor #(.FETCH_WIDTH(2), .BHT_DEPTH(64)) dut_a (
        .clk   (clk),
        .rst   (rst_a),
        .flush (flush_a),
        .bus   (if_a.slave)
    );

    bpu_bimodal_predictor #(.FETCH_WIDTH(4), .BHT_DEPTH(16)) dut_b (
        .clk   (clk),
        .rst   (rst_b),
        .flush (flush_b),
        .bus   (if_b.slave)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int fw_of(int s);    return (s == 0) ? 2 : 4;   endfunction
    function automatic int depth_of(int s); return (s == 0) ? 64 : 16; endfunction
    function automatic int idxw_of(int s);  return (s == 0) ? 6 : 4;   endfunction

    task automatic model_reset(input int s);
        for (int i = 0; i < 64; i++) begin
            m_cnt[s][i] = 2'b01;
            m_val[s][i] = 1'b0;
            m_tag[s][i] = '0;
            m_tgt[s][i] = '0;
        end
    endtask

    task automatic model_update(input int s, input logic [31:0] pc, input logic tk,
                                input logic [31:0] tgt);
        int idx;
        idx = int'((pc >> 2) & 32'(depth_of(s) - 1));
        if (tk) begin
            if (m_cnt[s][idx] != 2'b11) m_cnt[s][idx] = m_cnt[s][idx] + 2'd1;
            m_val[s][idx] = 1'b1;
            m_tag[s][idx] = pc >> (idxw_of(s) + 2);
            m_tgt[s][idx] = tgt;
        end else if (m_cnt[s][idx] != 2'b00) begin
            m_cnt[s][idx] = m_cnt[s][idx] - 2'd1;
        end
    endtask

    function automatic exp_t model_predict(input int s, input logic [31:0] pc,
                                           input logic [127:0] inst);
        exp_t        e;
        logic [31:0] pk;
        logic [5:0]  op;
        int          idx;
        logic        br;
        e.pc = pc; e.inst = inst; e.en = '0; e.br = '0;
        e.taken = 1'b0; e.slot = '0; e.tgt = '0;
        for (int k = 0; k < fw_of(s); k++) begin
            pk  = pc + 32'(4 * k);
            idx = int'((pk >> 2) & 32'(depth_of(s) - 1));
            op  = inst[32*k+26 +: 6];
            br  = (op >= 6'h12) && (op <= 6'h1B);
            e.br[k] = br;
            if (!e.taken) begin
                e.en[k] = 1'b1;
                if (br && m_cnt[s][idx][1] && m_val[s][idx] &&
                    (m_tag[s][idx] == (pk >> (idxw_of(s) + 2)))) begin
                    e.taken = 1'b1;
                    e.slot  = 2'(k);
                    e.tgt   = m_tgt[s][idx];
                end
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_upd(input int s, input logic v, input logic [31:0] pc,
                             input logic tk, input logic [31:0] tgt);
        if (s == 0) begin
            if_a.upd_valid_i = v; if_a.upd_pc_i = pc;
            if_a.upd_taken_i = tk; if_a.upd_target_i = tgt;
        end else begin
            if_b.upd_valid_i = v; if_b.upd_pc_i = pc;
            if_b.upd_taken_i = tk; if_b.upd_target_i = tgt;
        end
    endtask

    task automatic update(input int s, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt);
        drive_upd(s, 1'b1, pc, tk, tgt);
        model_update(s, pc, tk, tgt);
        tick();
        drive_upd(s, 1'b0, '0, 1'b0, '0);
    endtask

    // Presents one group for a single cycle, optionally with a same-cycle update.
    task automatic send_upd(input int s, input logic [31:0] pc, input logic [127:0] inst,
                            input logic uv, input logic [31:0] upc, input logic utk,
                            input logic [31:0] utgt);
        exp_t e;
        e = model_predict(s, pc, inst);
        if (uv) begin
            model_update(s, upc, utk, utgt);
            drive_upd(s, 1'b1, upc, utk, utgt);
        end
        if (s == 0) begin
            check("a_fetch_ready", if_a.fetch_ready_o, 1'b1);
            if_a.fetch_valid_i = 1'b1; if_a.pc_i = pc; if_a.inst_i = inst[63:0];
            q_a.push_back(e);
        end else begin
            check("b_fetch_ready", if_b.fetch_ready_o, 1'b1);
            if_b.fetch_valid_i = 1'b1; if_b.pc_i = pc; if_b.inst_i = inst;
            q_b.push_back(e);
        end
        tick();
        if (s == 0) if_a.fetch_valid_i = 1'b0;
        else        if_b.fetch_valid_i = 1'b0;
        if (uv) drive_upd(s, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic send(input int s, input logic [31:0] pc, input logic [127:0] inst);
        send_upd(s, pc, inst, 1'b0, '0, 1'b0, '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (if_a.pred_valid_o === 1'b1 && if_a.pred_ready_i === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_sb_underflow", 1'b1, 1'b0);
            end else begin
                e = q_a.pop_front();
                check("a_pc", if_a.pc_o, e.pc);
                check("a_inst", if_a.inst_o, e.inst[63:0]);
                check("a_inst_en", if_a.inst_en_o, e.en[1:0]);
                check("a_is_branch", if_a.is_branch_o, e.br[1:0]);
                check("a_taken", if_a.taken_o, e.taken);
                check("a_slot", if_a.taken_slot_o, e.slot[0]);
                check("a_target", if_a.branch_target_o, e.tgt);
            end
        end
        if (if_b.pred_valid_o === 1'b1 && if_b.pred_ready_i === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_sb_underflow", 1'b1, 1'b0);
            end else begin
                e = q_b.pop_front();
                check("b_pc", if_b.pc_o, e.pc);
                check("b_inst", if_b.inst_o, e.inst);
                check("b_inst_en", if_b.inst_en_o, e.en);
                check("b_is_branch", if_b.is_branch_o, e.br);
                check("b_taken", if_b.taken_o, e.taken);
                check("b_slot", if_b.taken_slot_o, e.slot);
                check("b_target", if_b.branch_target_o, e.tgt);
            end
        end
    end

    initial begin
        exp_t dropped;
        rst_a = 1'b0; rst_b = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
        if_a.fetch_valid_i = 1'b0; if_a.pc_i = '0; if_a.inst_i = '0; if_a.pred_ready_i = 1'b1;
        if_b.fetch_valid_i = 1'b0; if_b.pc_i = '0; if_b.inst_i = '0; if_b.pred_ready_i = 1'b1;
        drive_upd(0, 1'b0, '0, 1'b0, '0);
        drive_upd(1, 1'b0, '0, 1'b0, '0);
        model_reset(0);
        model_reset(1);
        tick();
        tick();
        check("rst_valid", if_a.pred_valid_o, 1'b0);
        check("rst_pc", if_a.pc_o, 32'h0);
        check("rst_en", if_a.inst_en_o, 2'b00);
        check("rst_taken", if_a.taken_o, 1'b0);
        check("rst_target", if_a.branch_target_o, 32'h0);
        check("rst_b_valid", if_b.pred_valid_o, 1'b0);
        rst_a = 1'b1; rst_b = 1'b1;

        // Plain ALU group, then a cold branch.
        send(0, 32'h1C00_0000, {64'h0, ADD, ADD});
        check("t1_valid", if_a.pred_valid_o, 1'b1);
        check("t1_en", if_a.inst_en_o, 2'b11);
        send(0, 32'h1C00_0000, {64'h0, ADD, BR});
        check("t2_br", if_a.is_branch_o, 2'b01);
        check("t2_taken", if_a.taken_o, 1'b0);

        // Train slot 1, then slot 0.
        update(0, 32'h1C00_0004, 1'b1, 32'h1C00_0100);
        update(0, 32'h1C00_0004, 1'b1, 32'h1C00_0100);
        send(0, 32'h1C00_0000, {64'h0, BR, ADD});
        check("t3_taken", if_a.taken_o, 1'b1);
        check("t3_slot", if_a.taken_slot_o, 1'b1);
        check("t3_target", if_a.branch_target_o, 32'h1C00_0100);
        update(0, 32'h1C00_0000, 1'b1, 32'h1C00_0200);
        update(0, 32'h1C00_0000, 1'b1, 32'h1C00_0200);
        send(0, 32'h1C00_0000, {64'h0, BR, BR});
        check("t3_slot0", if_a.taken_slot_o, 1'b0);
        check("t3_en0", if_a.inst_en_o, 2'b01);

        // Same index, different tag: BTB miss. Decode range edges.
        send(0, 32'h1C00_0104, {64'h0, ADD, BR});
        check("alias_taken", if_a.taken_o, 1'b0);
        send(0, 32'h1C00_0400, {64'h0, BRLO, BRHI});
        check("dec_in", if_a.is_branch_o, 2'b11);
        send(0, 32'h1C00_0408, {64'h0, NBLO, NBHI});
        check("dec_out", if_a.is_branch_o, 2'b00);

        // Saturation and hysteresis.
        for (int i = 0; i < 5; i++) update(0, 32'h1C00_0008, 1'b1, 32'h1C00_0300);
        update(0, 32'h1C00_0008, 1'b0, 32'h0);
        send(0, 32'h1C00_0008, {64'h0, ADD, BR});
        check("sat_taken", if_a.taken_o, 1'b1);
        check("sat_target", if_a.branch_target_o, 32'h1C00_0300);
        update(0, 32'h1C00_0008, 1'b0, 32'h0);
        update(0, 32'h1C00_0008, 1'b0, 32'h0);
        send(0, 32'h1C00_0008, {64'h0, ADD, BR});
        check("sat_nt", if_a.taken_o, 1'b0);

        // PC wrap: slot 1 sits at address 0.
        update(0, 32'h0000_0000, 1'b1, 32'h1C00_0500);
        update(0, 32'h0000_0000, 1'b1, 32'h1C00_0500);
        send(0, 32'hFFFF_FFFC, {64'h0, BR, ADD});
        check("wrap_slot", if_a.taken_slot_o, 1'b1);
        check("wrap_target", if_a.branch_target_o, 32'h1C00_0500);
        tick();
        check("idle_valid", if_a.pred_valid_o, 1'b0);
        check("idle_hold", if_a.pc_o, 32'hFFFF_FFFC);

        // Stall, then flush while stalled.
        if_a.pred_ready_i = 1'b0;
        send(0, 32'h1C00_0010, {64'h0, ADD, ADD});
        if_a.fetch_valid_i = 1'b1; if_a.pc_i = 32'h1C00_0020; if_a.inst_i = {ADD, ADD};
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", if_a.fetch_ready_o, 1'b0);
            check("stall_valid", if_a.pred_valid_o, 1'b1);
            check("stall_pc", if_a.pc_o, 32'h1C00_0010);
            tick();
        end
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        if_a.fetch_valid_i = 1'b0;
        check("flush_valid", if_a.pred_valid_o, 1'b0);
        check("flush_ready", if_a.fetch_ready_o, 1'b1);
        if (q_a.size() > 0) dropped = q_a.pop_front();
        if_a.pred_ready_i = 1'b1;
        send(0, 32'h1C00_0020, {64'h0, ADD, ADD});
        check("after_flush", if_a.pred_valid_o, 1'b1);
        tick();
        if_a.fetch_valid_i = 1'b1; if_a.pc_i = 32'h1C00_0030; if_a.inst_i = {ADD, ADD};
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        if_a.fetch_valid_i = 1'b0;
        check("flush_drop", if_a.pred_valid_o, 1'b0);

        // Collision: lookup sees the counter before the same-cycle update.
        update(0, 32'h1C00_0040, 1'b1, 32'h1C00_0600);
        send_upd(0, 32'h1C00_0040, {64'h0, ADD, BR}, 1'b1, 32'h1C00_0040, 1'b0, 32'h0);
        check("coll_old", if_a.taken_o, 1'b1);
        send(0, 32'h1C00_0040, {64'h0, ADD, BR});
        check("coll_new", if_a.taken_o, 1'b0);
        tick();

        // Reset while stalled drops the held group and clears the tables.
        if_a.pred_ready_i = 1'b0;
        send(0, 32'h1C00_0050, {64'h0, ADD, ADD});
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        check("rst_stall_valid", if_a.pred_valid_o, 1'b0);
        check("rst_stall_pc", if_a.pc_o, 32'h0);
        q_a.delete();
        model_reset(0);
        if_a.pred_ready_i = 1'b1;
        send(0, 32'h1C00_0000, {64'h0, BR, BR});
        check("rst_tables", if_a.taken_o, 1'b0);

        // Wide instance: slot 1, then slot 0, then last slot.
        update(1, 32'h1C00_0004, 1'b1, 32'h1C00_0100);
        update(1, 32'h1C00_0004, 1'b1, 32'h1C00_0100);
        send(1, 32'h1C00_0000, {ADD, ADD, BR, ADD});
        check("w_slot1", if_b.taken_slot_o, 2'd1);
        check("w_en1", if_b.inst_en_o, 4'b0011);
        update(1, 32'h1C00_0000, 1'b1, 32'h1C00_0200);
        update(1, 32'h1C00_0000, 1'b1, 32'h1C00_0200);
        send(1, 32'h1C00_0000, {ADD, ADD, BR, BR});
        check("w_slot0", if_b.taken_slot_o, 2'd0);
        check("w_en0", if_b.inst_en_o, 4'b0001);
        update(1, 32'h1C00_000C, 1'b1, 32'h1C00_0700);
        update(1, 32'h1C00_000C, 1'b1, 32'h1C00_0700);
        send(1, 32'h1C00_0000, {BR, ADD, ADD, ADD});
        check("w_slot3", if_b.taken_slot_o, 2'd3);
        check("w_target3", if_b.branch_target_o, 32'h1C00_0700);

        tick();
        tick();
        check("a_sb_drain", 128'(q_a.size()), 128'd0);
        check("b_sb_drain", 128'(q_b.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
